fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter that shares one `fifo_0r1w` write port between `NUM_REQ` requesters. It uses valid/ready handshakes toward the requesters and drives the FIFO's `i_push`/`i_wdata`/`o_full` directly. Optional burst locking keeps one requester granted until it signals last or reaches `MAX_BURST` beats. It sits in front of shared FIFOs, for example merged AXI response or event queues.

---
 rtl/fifo_wr_arbiter_if.sv | 28 ++
 rtl/fifo_wr_arbiter.sv | 125 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Shared FIFO write-port bundle: NUM_REQ valid/ready requesters on one side, one FIFO push port on the other.
// The master modport drives requests and FIFO status; the slave modport is the arbiter's view.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DWIDTH  = 32
);
   localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        i_req_valid;
   logic [NUM_REQ-1:0]        o_req_ready;
   logic [NUM_REQ*DWIDTH-1:0] i_req_data;
   logic [NUM_REQ-1:0]        i_req_last;
   logic                      o_push;
   logic [DWIDTH-1:0]         o_wdata;
   logic                      i_full;
   logic [IDW-1:0]            o_grant_id;
   logic                      o_busy;

   modport master (
      output i_req_valid, i_req_data, i_req_last, i_full,
      input  o_req_ready, o_push, o_wdata, o_grant_id, o_busy
   );

   modport slave (
      input  i_req_valid, i_req_data, i_req_last, i_full,
      output o_req_ready, o_push, o_wdata, o_grant_id, o_busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; zero-cycle valid/ready handshake, no push while full.
// Define FIFO_WR_ARBITER_LOCK_EN to hold a grant for a whole burst (up to MAX_BURST beats).
module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DWIDTH    = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   fifo_wr_arbiter_if.slave bus
);
   localparam int IDW = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

   logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
   logic [IDW-1:0]     rr_grant;
   logic [IDW-1:0]     cand;
   logic               rr_found;
   logic [IDW-1:0]     grant;
   logic               xfer;
   logic [NUM_REQ-1:0] ready;

   function automatic logic [IDW-1:0] next_id(input logic [IDW-1:0] id);
      return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
   endfunction

   // First valid requester at or after rr_ptr, wrapping; falls back to rr_ptr itself.
   always_comb begin
      rr_grant = rr_ptr_q;
      rr_found = 1'b0;
      cand     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!rr_found && bus.i_req_valid[cand]) begin
            rr_grant = cand;
            rr_found = 1'b1;
         end
      end
   end

   // Reset gates the handshake so nothing is pushed while the arbiter is held in reset.
   assign xfer = bus.i_req_valid[grant] & ~bus.i_full & i_rst_n;

   always_comb begin
      ready        = '0;
      ready[grant] = xfer;
   end

   assign bus.o_req_ready = ready;
   assign bus.o_push      = xfer;
   assign bus.o_wdata     = bus.i_req_data[int'(grant)*DWIDTH +: DWIDTH];
   assign bus.o_grant_id  = grant;

`ifdef FIFO_WR_ARBITER_LOCK_EN
   localparam int BCW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t         state_q, state_d;
   logic [IDW-1:0] lock_id_q, lock_id_d;
   logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

   assign grant      = (state_q == LOCKED) ? lock_id_q : rr_grant;
   assign bus.o_busy = (state_q == LOCKED);

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_id_d  = lock_id_q;
      beat_cnt_d = beat_cnt_q;
      if (xfer) begin
         if (state_q == IDLE) begin
            if (bus.i_req_last[grant] || MAX_BURST == 1) begin
               rr_ptr_d = next_id(grant);
            end else begin
               state_d    = LOCKED;
               lock_id_d  = grant;
               beat_cnt_d = BCW'(1);
            end
         end else if (bus.i_req_last[grant] || int'(beat_cnt_q) + 1 == MAX_BURST) begin
            state_d    = IDLE;
            rr_ptr_d   = next_id(lock_id_q);
            beat_cnt_d = '0;
         end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         lock_id_q  <= '0;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_id_q  <= lock_id_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end
`else
   // Without locking, last and MAX_BURST have no effect: every beat rotates the pointer.
   logic unused_cfg;
   assign unused_cfg = ^{bus.i_req_last, (MAX_BURST > 0)};

   assign grant      = rr_grant;
   assign bus.o_busy = 1'b0;

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (xfer) begin
         rr_ptr_d = next_id(grant);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table plus hand sequences; pushed data checked against a scoreboard queue.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 32;

   typedef struct {
      logic [N-1:0] v;
      logic [N-1:0] l;
      logic         f;
      logic [N-1:0] e_rdy;
      int           e_gnt;
      logic         e_busy;
   } vec_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_wr_arbiter_if #(.NUM_REQ(N), .DWIDTH(DW)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(N), .DWIDTH(DW), .MAX_BURST(4)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.slave)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   int            step_no  = 0;
   logic [DW-1:0] exp_q[$];
   vec_t          tbl[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Every FIFO push must match the oldest expected beat.
   always @(negedge clk) begin
      if (bus.o_push === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wdata: unexpected push of %0h with nothing expected", bus.o_wdata);
         end else begin
            chk("wdata", bus.o_wdata, exp_q.pop_front());
         end
      end
   end

   function automatic logic [DW-1:0] beat_data(input int s, input int k);
      return {8'(s), 8'(k), 16'h5A5A};
   endfunction

   task automatic step(input string nm, input logic [N-1:0] v, input logic [N-1:0] l, input logic f,
                       input logic [N-1:0] e_rdy, input int e_gnt, input logic e_busy);
      step_no++;
      for (int k = 0; k < N; k++) bus.i_req_data[k*DW +: DW] = beat_data(step_no, k);
      bus.i_req_valid = v;
      bus.i_req_last  = l;
      bus.i_full      = f;
      if (e_rdy != '0) exp_q.push_back(beat_data(step_no, e_gnt));
      @(negedge clk);
      chk({nm, ".ready"}, 32'(bus.o_req_ready), 32'(e_rdy));
      chk({nm, ".grant"}, 32'(bus.o_grant_id), 32'(e_gnt));
      chk({nm, ".push"},  32'(bus.o_push), 32'(e_rdy != '0));
      chk({nm, ".busy"},  32'(bus.o_busy), 32'(e_busy));
      @(posedge clk);
      #1;
   endtask

   // Asserts reset with every requester valid; outputs must drop without waiting for a clock.
   task automatic do_reset(input string nm);
      bus.i_req_valid = '1;
      bus.i_req_last  = '1;
      bus.i_full      = 1'b0;
      rst_n           = 1'b0;
      #1;
      chk({nm, ".rst_ready"}, 32'(bus.o_req_ready), 32'h0);
      chk({nm, ".rst_push"},  32'(bus.o_push), 32'h0);
      chk({nm, ".rst_busy"},  32'(bus.o_busy), 32'h0);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst_n           = 1'b1;
      bus.i_req_valid = '0;
   endtask

   initial begin
      bus.i_req_valid = '0;
      bus.i_req_last  = '0;
      bus.i_req_data  = '0;
      bus.i_full      = 1'b0;

      // Starting from rr_ptr=1 (after the single-requester beat); last set so both builds agree.
      tbl = '{
         '{4'b1111, 4'b1111, 1'b0, 4'b0010, 1, 1'b0},
         '{4'b1111, 4'b1111, 1'b0, 4'b0100, 2, 1'b0},
         '{4'b1111, 4'b1111, 1'b0, 4'b1000, 3, 1'b0},
         '{4'b1111, 4'b1111, 1'b0, 4'b0001, 0, 1'b0},
         '{4'b1111, 4'b1111, 1'b1, 4'b0000, 1, 1'b0},
         '{4'b0001, 4'b1111, 1'b0, 4'b0001, 0, 1'b0},
         '{4'b1000, 4'b1111, 1'b0, 4'b1000, 3, 1'b0},
         '{4'b0000, 4'b1111, 1'b0, 4'b0000, 0, 1'b0},
         '{4'b0110, 4'b1111, 1'b0, 4'b0010, 1, 1'b0},
         '{4'b0100, 4'b1111, 1'b0, 4'b0100, 2, 1'b0},
         '{4'b0011, 4'b1111, 1'b0, 4'b0001, 0, 1'b0},
         '{4'b0000, 4'b1111, 1'b0, 4'b0000, 1, 1'b0}
      };

      do_reset("init");
      step("idle", 4'b0000, 4'b0000, 1'b0, 4'b0000, 0, 1'b0);

      // Single requester: req0 pushes 0xA5 in the same cycle it is valid.
      bus.i_req_data        = '0;
      bus.i_req_data[31:0]  = 32'hA5;
      bus.i_req_valid       = 4'b0001;
      bus.i_req_last        = 4'b0001;
      bus.i_full            = 1'b0;
      exp_q.push_back(32'hA5);
      @(negedge clk);
      chk("single.ready", 32'(bus.o_req_ready), 32'h1);
      chk("single.push",  32'(bus.o_push), 32'h1);
      chk("single.wdata", bus.o_wdata, 32'hA5);
      @(posedge clk);
      #1;

      for (int i = 0; i < 12; i++) begin
         step($sformatf("vec%0d", i), tbl[i].v, tbl[i].l, tbl[i].f, tbl[i].e_rdy, tbl[i].e_gnt, tbl[i].e_busy);
      end

`ifdef FIFO_WR_ARBITER_LOCK_EN
      do_reset("lock");
      step("bl1", 4'b0110, 4'b0000, 1'b0, 4'b0010, 1, 1'b0);
      step("bl2", 4'b0110, 4'b0000, 1'b0, 4'b0010, 1, 1'b1);
      step("bl3", 4'b0110, 4'b0010, 1'b0, 4'b0010, 1, 1'b1);
      step("bl4", 4'b0100, 4'b0100, 1'b0, 4'b0100, 2, 1'b0);

      do_reset("cap");
      step("cap1", 4'b1001, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);
      for (int i = 2; i <= 4; i++) step($sformatf("cap%0d", i), 4'b1001, 4'b0000, 1'b0, 4'b0001, 0, 1'b1);
      step("cap5", 4'b1001, 4'b1000, 1'b0, 4'b1000, 3, 1'b0);

      do_reset("bp");
      step("bp1", 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 1'b0);
      step("bp2", 4'b0001, 4'b0000, 1'b0, 4'b0001, 0, 1'b1);
      for (int i = 0; i < 5; i++) step($sformatf("bp_full%0d", i), 4'b1001, 4'b0000, 1'b1, 4'b0000, 0, 1'b1);
      step("bp_drop", 4'b1000, 4'b0000, 1'b0, 4'b0000, 0, 1'b1);
      step("bp3", 4'b1001, 4'b0000, 1'b0, 4'b0001, 0, 1'b1);
      step("bp4", 4'b1001, 4'b0000, 1'b0, 4'b0001, 0, 1'b1);
      step("bp5", 4'b1001, 4'b1000, 1'b0, 4'b1000, 3, 1'b0);
`else
      do_reset("rr");
      for (int i = 0; i < 5; i++) step($sformatf("rr%0d", i), 4'b1111, 4'b0000, 1'b0, 4'(1 << (i % N)), i % N, 1'b0);
`endif

      do_reset("mid");
      step("mid1", 4'b0100, 4'b0000, 1'b0, 4'b0100, 2, 1'b0);
`ifdef FIFO_WR_ARBITER_LOCK_EN
      step("mid2", 4'b0100, 4'b0000, 1'b0, 4'b0100, 2, 1'b1);
`else
      step("mid2", 4'b0100, 4'b0000, 1'b0, 4'b0100, 2, 1'b0);
`endif
      do_reset("midrst");
      step("after_rst", 4'b1111, 4'b1111, 1'b0, 4'b0001, 0, 1'b0);

      chk("scoreboard_drain", 32'(exp_q.size()), 32'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
